// File: rtl/initial_config_writer.sv
// rtl/initial_config_writer.sv - power-on register table writer over a 3-wire serial bus
// Walks NUM_WORDS LUT entries and shifts each MSB-first on SCEN/SCLK/SDA, then flags oDONE.
module initial_config_writer #(
  parameter int CLK_DIV    = 16,
  parameter int WORD_W     = 16,
  parameter int NUM_WORDS  = 20,
  parameter int IDX_W      = 5,
  parameter int GAP_CYCLES = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iINITIAL_START,
  output logic [IDX_W-1:0]  oWORD_IDX,
  input  logic [WORD_W-1:0] iWORD_DATA,
  output logic              oSCEN,
  output logic              oSCLK,
  output logic              oSDA,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(WORD_W);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  state_t            state, stateNxt;
  logic [WORD_W-1:0] shReg, shRegNxt;
  logic [DIV_W-1:0]  divCnt, divCntNxt;
  logic [BIT_W-1:0]  bitCnt, bitCntNxt;
  logic [GAP_W-1:0]  gapCnt, gapCntNxt;
  logic [IDX_W-1:0]  idxNxt;
  logic              scenNxt, sclkNxt, sdaNxt, busyNxt, doneNxt;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      shReg     <= '0;
      divCnt    <= '0;
      bitCnt    <= '0;
      gapCnt    <= '0;
      oWORD_IDX <= '0;
      oSCEN     <= 1'b1;
      oSCLK     <= 1'b0;
      oSDA      <= 1'b0;
      oBUSY     <= 1'b0;
      oDONE     <= 1'b0;
    end else begin
      state     <= stateNxt;
      shReg     <= shRegNxt;
      divCnt    <= divCntNxt;
      bitCnt    <= bitCntNxt;
      gapCnt    <= gapCntNxt;
      oWORD_IDX <= idxNxt;
      oSCEN     <= scenNxt;
      oSCLK     <= sclkNxt;
      oSDA      <= sdaNxt;
      oBUSY     <= busyNxt;
      oDONE     <= doneNxt;
    end
  end

  always_comb begin
    stateNxt  = state;
    shRegNxt  = shReg;
    divCntNxt = divCnt;
    bitCntNxt = bitCnt;
    gapCntNxt = gapCnt;
    idxNxt    = oWORD_IDX;
    scenNxt   = oSCEN;
    sclkNxt   = oSCLK;
    sdaNxt    = oSDA;
    busyNxt   = oBUSY;
    doneNxt   = oDONE;
    case (state)
      IDLE: begin
        busyNxt = 1'b0;
        if (iINITIAL_START) begin
          idxNxt   = '0;
          doneNxt  = 1'b0;
          busyNxt  = 1'b1;
          stateNxt = LOAD;
        end
      end
      LOAD: begin
        shRegNxt  = iWORD_DATA;
        scenNxt   = 1'b0;
        sdaNxt    = iWORD_DATA[WORD_W-1];
        bitCntNxt = '0;
        divCntNxt = '0;
        stateNxt  = SHIFT;
      end
      SHIFT: begin
        // SDA only moves on the falling SCLK edge, so it is stable across every rise
        if (divCnt == DIV_LAST) begin
          sclkNxt = 1'b0;
          if (bitCnt == BIT_LAST) begin
            scenNxt   = 1'b1;
            sdaNxt    = 1'b0;
            gapCntNxt = '0;
            stateNxt  = GAP;
          end else begin
            bitCntNxt = bitCnt + 1'b1;
            divCntNxt = '0;
            shRegNxt  = shReg << 1;
            sdaNxt    = shReg[WORD_W-2];
          end
        end else begin
          divCntNxt = divCnt + 1'b1;
          if (divCnt == DIV_HALF) sclkNxt = 1'b1;
        end
      end
      GAP: begin
        if (gapCnt == GAP_LAST) begin
          if (oWORD_IDX == IDX_LAST) begin
            doneNxt  = 1'b1;
            busyNxt  = 1'b0;
            idxNxt   = '0;
            stateNxt = IDLE;
          end else begin
            idxNxt   = oWORD_IDX + 1'b1;
            stateNxt = LOAD;
          end
        end else begin
          gapCntNxt = gapCnt + 1'b1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_initial_config_writer.sv
// tb/tb_initial_config_writer.sv - directed bench for initial_config_writer
// Two instances: a single-word table and a three-word table, observed by one serial receiver.
module tb_initial_config_writer;

  localparam int GAP = 8;
  localparam int WORD_CYC = 1 + 2 * 2 * 16 + GAP;

  logic iCLK = 1'b0;
  logic iRST, start1, start3, sel;
  logic [4:0]  idx1, idx3;
  logic [15:0] word1, word3;
  logic scen1, sclk1, sda1, busy1, done1;
  logic scen3, sclk3, sda3, busy3, done3;
  logic mScen, mSclk, mSda, mBusy, mDone;

  always #5 iCLK = ~iCLK;

  assign word1 = 16'hA5C3;
  always_comb begin
    case (idx3)
      5'd0:    word3 = 16'h1234;
      5'd1:    word3 = 16'h5678;
      5'd2:    word3 = 16'h9ABC;
      default: word3 = 16'h0000;
    endcase
  end

  initial_config_writer #(.CLK_DIV(2), .WORD_W(16), .NUM_WORDS(1), .IDX_W(5), .GAP_CYCLES(GAP)) dut1 (
    .iCLK(iCLK), .iRST(iRST), .iINITIAL_START(start1), .oWORD_IDX(idx1), .iWORD_DATA(word1),
    .oSCEN(scen1), .oSCLK(sclk1), .oSDA(sda1), .oBUSY(busy1), .oDONE(done1));

  initial_config_writer #(.CLK_DIV(2), .WORD_W(16), .NUM_WORDS(3), .IDX_W(5), .GAP_CYCLES(GAP)) dut3 (
    .iCLK(iCLK), .iRST(iRST), .iINITIAL_START(start3), .oWORD_IDX(idx3), .iWORD_DATA(word3),
    .oSCEN(scen3), .oSCLK(sclk3), .oSDA(sda3), .oBUSY(busy3), .oDONE(done3));

  assign mScen = sel ? scen3 : scen1;
  assign mSclk = sel ? sclk3 : sclk1;
  assign mSda  = sel ? sda3  : sda1;
  assign mBusy = sel ? busy3 : busy1;
  assign mDone = sel ? done3 : done1;

  int nChecks = 0;
  int nFails  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Serial receiver: frames close when SCEN rises
  logic [15:0] shiftW = '0;
  int bitsSeen = 0, lowCnt = 0, highCnt = 0, sdaGlitch = 0, sclkRises = 0;
  logic [15:0] frames[$];
  int lowLens[$], bitLens[$], highLens[$];

  initial begin
    logic pScen, pSclk, pSda;
    pScen = 1'b1; pSclk = 1'b0; pSda = 1'b0;
    forever begin
      @(negedge iCLK);
      if (pSclk === 1'b0 && mSclk === 1'b1) begin
        sclkRises++;
        if (mSda !== pSda) sdaGlitch++;
        if (mScen === 1'b0) begin
          shiftW = {shiftW[14:0], mSda};
          bitsSeen++;
        end
      end
      if (mScen === 1'b0) begin
        if (pScen === 1'b1) begin
          if (frames.size() > 0) highLens.push_back(highCnt);
          highCnt = 0;
        end
        lowCnt++;
      end else if (mScen === 1'b1) begin
        if (pScen === 1'b0) begin
          frames.push_back(shiftW);
          lowLens.push_back(lowCnt);
          bitLens.push_back(bitsSeen);
          lowCnt = 0;
          bitsSeen = 0;
          highCnt = 1;
        end else begin
          highCnt++;
        end
      end
      pScen = mScen; pSclk = mSclk; pSda = mSda;
    end
  end

  task automatic pulseStart(input logic which3);
    if (which3) start3 = 1'b1; else start1 = 1'b1;
    @(negedge iCLK);
    start1 = 1'b0;
    start3 = 1'b0;
  endtask

  task automatic waitDone(input int limit, input bit pulses, output int n);
    n = 0;
    while (!mDone && n < limit) begin
      if (pulses) start3 = ((n % 10) == 5) || (n == WORD_CYC * 3 - 1);
      @(negedge iCLK);
      n++;
    end
    start3 = 1'b0;
  endtask

  initial begin
    int n, base, rises;
    iRST = 1'b1; start1 = 1'b0; start3 = 1'b0; sel = 1'b0;
    repeat (3) @(negedge iCLK);
    check("rst_scen", 32'(scen3), 32'd1);
    check("rst_sclk", 32'(sclk3), 32'd0);
    check("rst_sda", 32'(sda3), 32'd0);
    check("rst_busy", 32'(busy3), 32'd0);
    check("rst_done", 32'(done3), 32'd0);
    check("rst_idx", 32'(idx3), 32'd0);
    iRST = 1'b0;
    @(negedge iCLK);

    // Single-word table
    base = frames.size();
    pulseStart(1'b0);
    check("w1_busy_after_start", 32'(busy1), 32'd1);
    waitDone(2000, 1'b0, n);
    check("w1_done_latency", 32'(n), 32'(WORD_CYC));
    check("w1_frames", 32'(frames.size() - base), 32'd1);
    check("w1_word", 32'(frames[base]), 32'hA5C3);
    check("w1_scen_low", 32'(lowLens[base]), 32'd64);
    check("w1_bits", 32'(bitLens[base]), 32'd16);
    check("w1_busy_end", 32'(busy1), 32'd0);

    // Three-word table
    sel = 1'b1;
    @(negedge iCLK);
    base = frames.size();
    pulseStart(1'b1);
    waitDone(2000, 1'b0, n);
    check("w3_done_latency", 32'(n), 32'(3 * WORD_CYC));
    check("w3_frames", 32'(frames.size() - base), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("w3_word%0d", i), 32'(frames[base+i]), 32'(i == 0 ? 16'h1234 : i == 1 ? 16'h5678 : 16'h9ABC));
      check($sformatf("w3_low%0d", i), 32'(lowLens[base+i]), 32'd64);
    end
    // SCEN stays high through the gap plus the one-cycle fetch of the next word
    check("w3_gap_a", 32'(highLens[highLens.size()-2]), 32'(GAP + 1));
    check("w3_gap_b", 32'(highLens[highLens.size()-1]), 32'(GAP + 1));

    // Restart after done, with stray pulses during the sequence and on the done edge
    repeat (3) @(negedge iCLK);
    base = frames.size();
    pulseStart(1'b1);
    check("re_done_cleared", 32'(done3), 32'd0);
    check("re_idx0", 32'(idx3), 32'd0);
    waitDone(2000, 1'b1, n);
    check("re_latency", 32'(n), 32'(3 * WORD_CYC));
    check("re_frames", 32'(frames.size() - base), 32'd3);
    check("re_first_word", 32'(frames[base]), 32'h1234);
    check("re_last_word", 32'(frames[base+2]), 32'h9ABC);
    repeat (3) @(negedge iCLK);
    check("re_no_restart_busy", 32'(busy3), 32'd0);
    check("re_done_held", 32'(done3), 32'd1);

    // Reset in the middle of word 1, bit 7
    base = frames.size();
    pulseStart(1'b1);
    n = 0;
    while (!(frames.size() == base + 1 && bitsSeen == 7) && n < 2000) begin
      @(negedge iCLK);
      n++;
    end
    check("mid_reached", 32'(n < 2000), 32'd1);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    check("mid_scen", 32'(scen3), 32'd1);
    check("mid_sclk", 32'(sclk3), 32'd0);
    check("mid_idx", 32'(idx3), 32'd0);
    check("mid_busy", 32'(busy3), 32'd0);
    check("mid_done", 32'(done3), 32'd0);
    rises = sclkRises;
    repeat (200) @(negedge iCLK);
    check("mid_no_sclk", 32'(sclkRises), 32'(rises));
    check("mid_scen_idle", 32'(scen3), 32'd1);

    // Reset and start together
    iRST = 1'b1; start3 = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0; start3 = 1'b0;
    check("rs_busy0", 32'(busy3), 32'd0);
    repeat (20) @(negedge iCLK);
    check("rs_busy_later", 32'(busy3), 32'd0);
    check("rs_no_sclk", 32'(sclkRises), 32'(rises));

    check("sda_stable_on_rise", 32'(sdaGlitch), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
